fc_spike_vote_classifier: RTL and testbench
===========================================

# fc_spike_vote_classifier

Output-decision stage directly downstream of the two-layer fully-connected SNN core. It consumes the output-layer spike stream (`w_en` / `s_index_o`, one spike index per valid cycle) and accumulates per-class spike counts over one inference frame. At frame end it performs a sequential argmax over the class counters and emits one classification result. It then clears the counters for reuse, while a second counter bank accepts the next frame's spikes without stalling.

## Interface
Parameters:
- `NUM_CLASS`, 10: number of output neurons/classes; legal range 2..16.
- `CNT_W`, 8: per-class counter width; counters saturate at 2^CNT_W−1.
- `IDX_W`, `SYNAPSE_INDEX` (16): spike index width, matching the core's output.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `spike_valid`  in  1: spike present; driven by the core's `w_en`.
- `spike_index`  in  IDX_W: firing class index; driven by the core's `s_index_o`.
- `frame_end`  in  1: one-cycle pulse marking the last cycle of the current frame.
- `class_valid`  out  1: one-cycle result strobe.
- `class_id`  out  4: winning class; held until the next `class_valid`.
- `class_count`  out  CNT_W: spike count of the winner; held with `class_id`.
- `tie`  out  1: another class equalled the winner's count; held with `class_id`.
- `busy`  out  1: scan in progress.
- `err_range`  out  1: sticky; set on a spike with `spike_index >= NUM_CLASS`.
- `err_overrun`  out  1: sticky; set on `frame_end` while `busy`.

## Operation
- Two banks of NUM_CLASS counters, each CNT_W bits. `act` selects the accumulate bank; the other bank is the scan bank.
- Accumulate, in every state: on `spike_valid` with in-range index, `bank[act][spike_index]` increments and saturates at max.
  - An out-of-range index sets `err_range` and changes no counter.
- FSM states: IDLE, SCAN, DONE.
- IDLE: on `frame_end`, toggle `act`, set `scan_idx=0`, clear `best_cnt`/`best_id`/`tie_r`, and go to SCAN.
  - A spike in the same cycle as `frame_end` counts into the ending frame's bank, which is the old `act`.
- SCAN, one class per cycle, reading `bank[~act][scan_idx]`:
  - If `cnt > best_cnt`: the class becomes the winner and `tie_r` clears.
  - Else if `cnt == best_cnt` and `scan_idx != 0`: set `tie_r`.
  - The entry is zeroed in the same cycle.
  - After `scan_idx == NUM_CLASS−1`, go to DONE.
  - The lowest index wins ties. An all-zero frame yields `class_id=0`, `class_count=0`, `tie=1`.
- DONE: register the outputs, pulse `class_valid` for one cycle, return to IDLE.
- `frame_end` while in SCAN or DONE: ignored, `err_overrun` sets, and no bank swap occurs. Spikes keep accumulating into `act`.
- The core is never back-pressured; this block has no ready output.
- Sticky error flags clear only on `rst`.

## Timing
- Reset values:
  - All counters 0; `act=0`; state IDLE.
  - `class_valid=0`, `class_id=0`, `class_count=0`, `tie=0`, `busy=0`, `err_range=0`, `err_overrun=0`.
- Reset asserted mid-scan aborts immediately. No `class_valid` is produced, and both banks are zero after release.
- Cycle timing, with `frame_end` sampled at edge E:
  - `busy` is high from E+1 through E+NUM_CLASS+1 inclusive.
  - The SCAN edges are E+1..E+NUM_CLASS.
  - DONE is the cycle after edge E+NUM_CLASS; `class_valid` is asserted at edge E+NUM_CLASS+1.
  - For NUM_CLASS=10, `class_valid` is high in the 11th cycle after `frame_end`.
- The minimum `frame_end` spacing without overrun is NUM_CLASS+2 cycles.
- A spike is counted on the edge at which `spike_valid` is sampled, with no latency to the counter.
- `class_id`/`class_count`/`tie` change only together with `class_valid`.

## Structure
- Add `CLS_NUM` (10), `CLS_CNT_W` (8), and the FSM state encodings to the shared `define.vh`, next to `SYNAPSE_INDEX`.
- One sub-module, `spike_count_bank`, implements a single bank:
  - NUM_CLASS saturating counters;
  - an increment port (`inc_en`, `inc_idx`);
  - a read-and-clear port (`rd_idx`, `clr_en`, `rd_cnt`, combinational read).
- The top instantiates two banks. It muxes the increment and scan ports by `act`, and holds the FSM, argmax registers and error flags.

## Test plan
- Single frame:
  - Stimulus: 3 spikes idx 4, 5 spikes idx 7, 1 spike idx 0, then `frame_end`.
  - Required: `class_valid` 11 cycles later with `class_id=7`, `class_count=5`, `tie=0`.
- Tie and empty frames:
  - Stimulus: 4 spikes each on idx 2 and idx 6.
  - Required: `class_id=2`, `class_count=4`, `tie=1`.
  - Stimulus: empty frame.
  - Required: `class_id=0`, `class_count=0`, `tie=1`.
- Saturation and range:
  - Stimulus: 300 spikes on idx 3.
  - Required: `class_count=255`.
  - Stimulus: a spike on idx 12.
  - Required: `err_range=1` and no counter change.
- Overlap:
  - Stimulus: frame A (idx 1 ×2); `frame_end`; during SCAN, frame B (idx 9 ×3); second `frame_end` 12 cycles after the first.
  - Required: results A→1/2, then B→9/3. A spike coincident with the first `frame_end` is counted in A.
- Overrun:
  - Stimulus: `frame_end` 5 cycles after a previous `frame_end`.
  - Required: `err_overrun=1`, exactly one `class_valid`, and the second frame's spikes retained for the next frame.
- Reset mid-scan:
  - Stimulus: assert `rst` at scan cycle 4.
  - Required: all outputs 0 and no `class_valid`. After release, a frame with idx 8 ×1 yields `class_id=8`, `class_count=1`.

Source files
------------

// File: rtl/fc_spike_vote_classifier_pkg.sv
// Shared constants and FSM encoding for the spike-vote output classifier.
// Kept alongside the core's spike index width so both sides agree on sizing.
package fc_spike_vote_classifier_pkg;

  localparam int SYNAPSE_INDEX = 16;
  localparam int CLS_NUM       = 10;
  localparam int CLS_CNT_W     = 8;
  localparam int CLS_ID_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } cls_state_e;

endpackage

// File: rtl/fc_spike_vote_classifier_spike_count_bank.sv
// One bank of per-class saturating spike counters with an increment port
// and a combinational read-and-clear port used by the argmax scan.
module spike_count_bank
  import fc_spike_vote_classifier_pkg::*;
#(
  parameter int NUM_CLASS = CLS_NUM,
  parameter int CNT_W     = CLS_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_en,
  input  logic [CLS_ID_W-1:0] inc_idx,
  input  logic                clr_en,
  input  logic [CLS_ID_W-1:0] rd_idx,
  output logic [CNT_W-1:0]    rd_cnt
);

  logic [CNT_W-1:0] r_cnt [NUM_CLASS];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASS; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        // The top never clears and increments the same bank in one cycle.
        if (clr_en && rd_idx == CLS_ID_W'(i))
          r_cnt[i] <= '0;
        else if (inc_en && inc_idx == CLS_ID_W'(i))
          r_cnt[i] <= sat_inc(r_cnt[i]);
      end
    end
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NUM_CLASS; i++)
      if (rd_idx == CLS_ID_W'(i)) rd_cnt = r_cnt[i];
  end

endmodule

// File: rtl/fc_spike_vote_classifier.sv
// Per-frame spike-count voting: two ping-pong counter banks, a sequential
// argmax scan over the retired bank, and sticky range/overrun error flags.
module fc_spike_vote_classifier
  import fc_spike_vote_classifier_pkg::*;
#(
  parameter int NUM_CLASS = CLS_NUM,
  parameter int CNT_W     = CLS_CNT_W,
  parameter int IDX_W     = SYNAPSE_INDEX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                spike_valid,
  input  logic [IDX_W-1:0]    spike_index,
  input  logic                frame_end,
  output logic                class_valid,
  output logic [CLS_ID_W-1:0] class_id,
  output logic [CNT_W-1:0]    class_count,
  output logic                tie,
  output logic                busy,
  output logic                err_range,
  output logic                err_overrun
);

  cls_state_e          r_state;
  cls_state_e          w_state_nx;
  logic                r_act;
  logic [CLS_ID_W-1:0] r_scan_idx;
  logic [CNT_W-1:0]    r_best_cnt;
  logic [CLS_ID_W-1:0] r_best_id;
  logic                r_tie;

  logic                w_in_range;
  logic                w_inc;
  logic                w_scan;
  logic                w_last;
  logic [CNT_W-1:0]    w_rd_cnt0;
  logic [CNT_W-1:0]    w_rd_cnt1;
  logic [CNT_W-1:0]    w_rd_cnt;
  logic [CNT_W-1:0]    w_best_cnt_nx;
  logic [CLS_ID_W-1:0] w_best_id_nx;
  logic                w_tie_nx;

  assign w_in_range = spike_index < IDX_W'(NUM_CLASS);
  assign w_inc      = spike_valid && w_in_range;
  assign w_scan     = (r_state == ST_SCAN);
  assign w_last     = (r_scan_idx == CLS_ID_W'(NUM_CLASS - 1));
  assign w_rd_cnt   = r_act ? w_rd_cnt0 : w_rd_cnt1;

  // Bank r_act accumulates; bank ~r_act is scanned and cleared.
  spike_count_bank #(.NUM_CLASS(NUM_CLASS), .CNT_W(CNT_W)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (w_inc && !r_act),
    .inc_idx (spike_index[CLS_ID_W-1:0]),
    .clr_en  (w_scan && r_act),
    .rd_idx  (r_scan_idx),
    .rd_cnt  (w_rd_cnt0)
  );

  spike_count_bank #(.NUM_CLASS(NUM_CLASS), .CNT_W(CNT_W)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .inc_en  (w_inc && r_act),
    .inc_idx (spike_index[CLS_ID_W-1:0]),
    .clr_en  (w_scan && !r_act),
    .rd_idx  (r_scan_idx),
    .rd_cnt  (w_rd_cnt1)
  );

  always_comb begin
    w_best_cnt_nx = r_best_cnt;
    w_best_id_nx  = r_best_id;
    w_tie_nx      = r_tie;
    if (w_rd_cnt > r_best_cnt) begin
      w_best_cnt_nx = w_rd_cnt;
      w_best_id_nx  = r_scan_idx;
      w_tie_nx      = 1'b0;
    end else if (w_rd_cnt == r_best_cnt && r_scan_idx != '0) begin
      w_tie_nx      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (frame_end) w_state_nx = ST_SCAN;
      ST_SCAN: if (w_last)    w_state_nx = ST_DONE;
      ST_DONE:                w_state_nx = ST_IDLE;
      default:                w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_act       <= 1'b0;
      r_scan_idx  <= '0;
      r_best_cnt  <= '0;
      r_best_id   <= '0;
      r_tie       <= 1'b0;
      class_id    <= '0;
      class_count <= '0;
      tie         <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && frame_end) begin
        r_act      <= !r_act;
        r_scan_idx <= '0;
        r_best_cnt <= '0;
        r_best_id  <= '0;
        r_tie      <= 1'b0;
      end else if (w_scan) begin
        r_scan_idx <= r_scan_idx + 1'b1;
        r_best_cnt <= w_best_cnt_nx;
        r_best_id  <= w_best_id_nx;
        r_tie      <= w_tie_nx;
        // Result registers load on the last scan edge so they change exactly as class_valid rises.
        if (w_last) begin
          class_id    <= w_best_id_nx;
          class_count <= w_best_cnt_nx;
          tie         <= w_tie_nx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_range   <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (spike_valid && !w_in_range)       err_range   <= 1'b1;
      if (frame_end && r_state != ST_IDLE)  err_overrun <= 1'b1;
    end
  end

  assign class_valid = (r_state == ST_DONE);
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_fc_spike_vote_classifier.sv
// Directed-vector bench: stimulus pushes hand-computed results into a queue,
// an independent monitor pops and compares on every class_valid.
module tb_fc_spike_vote_classifier;

  localparam int NCLS = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        spike_valid;
  logic [15:0] spike_index;
  logic        frame_end;
  logic        class_valid;
  logic [3:0]  class_id;
  logic [7:0]  class_count;
  logic        tie;
  logic        busy;
  logic        err_range;
  logic        err_overrun;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int id;
    int cnt;
    int tie;
    int cyc;
  } exp_t;

  exp_t q[$];

  fc_spike_vote_classifier dut (
    .clk         (clk),
    .rst         (rst),
    .spike_valid (spike_valid),
    .spike_index (spike_index),
    .frame_end   (frame_end),
    .class_valid (class_valid),
    .class_id    (class_id),
    .class_count (class_count),
    .tie         (tie),
    .busy        (busy),
    .err_range   (err_range),
    .err_overrun (err_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic spikes(input int idx, input int n);
    for (int k = 0; k < n; k++) begin
      spike_valid = 1'b1;
      spike_index = 16'(idx);
      tick();
    end
    spike_valid = 1'b0;
  endtask

  // frame_end is sampled at the next edge E; the result is due in the DONE
  // cycle, i.e. observed on the falling edge while cyc == E + NCLS.
  task automatic fend(input bit push, input int id, input int cnt, input int t,
                      input bit sp = 1'b0, input int sidx = 0);
    exp_t e;
    frame_end   = 1'b1;
    spike_valid = sp;
    spike_index = 16'(sidx);
    if (push) begin
      e.id  = id;
      e.cnt = cnt;
      e.tie = t;
      e.cyc = cyc + 1 + NCLS;
      q.push_back(e);
    end
    tick();
    frame_end   = 1'b0;
    spike_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_class_valid"}, int'(class_valid), 0);
    chk({tag, "_class_id"},    int'(class_id),    0);
    chk({tag, "_class_count"}, int'(class_count), 0);
    chk({tag, "_tie"},         int'(tie),         0);
    chk({tag, "_busy"},        int'(busy),        0);
    chk({tag, "_err_range"},   int'(err_range),   0);
    chk({tag, "_err_overrun"}, int'(err_overrun), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (class_valid === 1'b1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got class_id=%0d count=%0d at cycle %0d, expected no result",
                 class_id, class_count, cyc);
      end else begin
        e = q.pop_front();
        chk("valid_cycle", cyc,              e.cyc);
        chk("class_id",    int'(class_id),    e.id);
        chk("class_count", int'(class_count), e.cnt);
        chk("tie",         int'(tie),         e.tie);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b1;
    spike_valid = 1'b0;
    spike_index = '0;
    frame_end   = 1'b0;
    tick(3);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(2);

    // Single frame with busy window
    spikes(4, 3);
    spikes(7, 5);
    spikes(0, 1);
    fend(1'b1, 7, 5, 0);
    chk("busy_first", int'(busy), 1);
    tick(NCLS);
    chk("busy_last", int'(busy), 1);
    tick();
    chk("busy_after", int'(busy), 0);
    tick(2);

    // Tie and empty frames
    for (int k = 0; k < 4; k++) begin
      spikes(6, 1);
      spikes(2, 1);
    end
    fend(1'b1, 2, 4, 1);
    tick(NCLS + 2);
    fend(1'b1, 0, 0, 1);
    tick(NCLS + 2);

    // Saturation, then out-of-range spike leaves counters untouched
    spikes(3, 300);
    chk("err_range_pre", int'(err_range), 0);
    fend(1'b1, 3, 255, 0);
    tick(NCLS + 2);
    spikes(12, 1);
    chk("err_range_set", int'(err_range), 1);
    fend(1'b1, 0, 0, 1);
    tick(NCLS + 2);

    // Overlap: coincident spike joins frame A, frame B fills during scan
    spikes(1, 1);
    fend(1'b1, 1, 2, 0, 1'b1, 1);
    spikes(9, 3);
    tick(8);
    fend(1'b1, 9, 3, 0);
    chk("err_overrun_legal", int'(err_overrun), 0);
    tick(NCLS + 2);

    // Overrun: second frame_end 5 cycles later is dropped, spikes retained
    spikes(5, 1);
    fend(1'b1, 5, 1, 0);
    spikes(8, 2);
    tick(2);
    fend(1'b0, 0, 0, 0);
    chk("err_overrun_set", int'(err_overrun), 1);
    tick(8);
    chk("busy_after_overrun", int'(busy), 0);
    fend(1'b1, 8, 2, 0);
    tick(NCLS + 2);
    chk("err_range_sticky", int'(err_range), 1);

    // Reset mid-scan aborts without a result and clears both banks
    spikes(3, 2);
    fend(1'b0, 0, 0, 0);
    tick(3);
    rst = 1'b1;
    #1;
    chk_all_zero("midscan");
    tick(2);
    rst = 1'b0;
    tick(NCLS + 4);
    spikes(8, 1);
    fend(1'b1, 8, 1, 0);
    tick(NCLS + 4);

    chk("pending_results", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
